// File: rtl/register_bank_scanner_pkg.sv
// scanner_pkg: scan state encoding and width helper shared by the register bank scanner
package scanner_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/register_bank_scanner_tick_generator.sv
// tick_generator: free-running divider producing a registered one-cycle bank enable
module tick_generator
  import scanner_pkg::*;
#(
  parameter int TickDivide = 1
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick
);
  localparam int CntW = (clog2(TickDivide) < 1) ? 1 : clog2(TickDivide);
  localparam logic [CntW-1:0] Last = CntW'(TickDivide - 1);
  logic [CntW-1:0] cnt, cnt_nx;
  assign cnt_nx = (cnt == Last) ? '0 : cnt + CntW'(1);
  // Tick is registered from the next count so it stays low while in reset
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      Tick <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      Tick <= (cnt_nx == Last);
    end
endmodule

// File: rtl/register_bank_scanner.sv
// register_bank_scanner: walks a tri-state register bank one cs at a time and streams the words out
module register_bank_scanner
  import scanner_pkg::*;
#(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4,
  parameter int TickDivide = 1,
  localparam int IdxW = (clog2(NrOfRegs) < 1) ? 1 : clog2(NrOfRegs)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [NrOfBits-1:0] BusIn,
  input  logic                OutReady,
  output logic [NrOfRegs-1:0] cs,
  output logic                Tick,
  output logic [NrOfBits-1:0] OutData,
  output logic [IdxW-1:0]     OutIndex,
  output logic                OutValid,
  output logic                Busy,
  output logic                Done
);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrOfRegs - 1);
  logic [1:0] state, state_nx;
  logic [IdxW-1:0] idx, idx_nx;
  tick_generator #(.TickDivide(TickDivide)) u_tick (
    .Clock(Clock),
    .Reset(Reset),
    .Tick(Tick)
  );
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      ST_IDLE: if (Start) begin
        state_nx = ST_SELECT;
        idx_nx = '0;
      end
      ST_SELECT: state_nx = ST_OUTPUT;
      ST_OUTPUT: if (OutReady) begin
        state_nx = (idx == LastIdx) ? ST_DONE : ST_SELECT;
        idx_nx = (idx == LastIdx) ? idx : idx + IdxW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  // cs is decoded from the next state so the select line leaves a flop, never a gate
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= ST_IDLE;
      idx <= '0;
      cs <= '1;
      OutData <= '0;
      OutIndex <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cs <= (state_nx == ST_SELECT) ? ~(NrOfRegs'(1) << idx_nx) : '1;
      if (state == ST_SELECT) begin
        OutData <= BusIn;
        OutIndex <= idx;
      end
    end
  assign OutValid = (state == ST_OUTPUT);
  assign Busy = (state != ST_IDLE);
  assign Done = (state == ST_DONE);
endmodule

// File: tb/tb_register_bank_scanner.sv
// tb_register_bank_scanner: scoreboard bench with a bus model and randomized backpressure
module tb_register_bank_scanner;
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
  } word_t;
  logic Clock = 1'b0;
  logic Reset, Start, OutReady;
  logic [7:0] BusIn, OutData;
  logic [3:0] cs;
  logic [1:0] OutIndex;
  logic Tick, OutValid, Busy, Done, tick1;
  logic [7:0] regs [4];
  logic [9:0] vmask, dmask;
  word_t sb[$];
  word_t mon_w;
  int nchecks = 0, nerr = 0, jcnt = 0, done_cnt = 0, exp_done = 0, acc_cnt = 0, a0;
  register_bank_scanner #(.NrOfBits(8), .NrOfRegs(4), .TickDivide(3)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .BusIn(BusIn),
    .OutReady(OutReady),
    .cs(cs),
    .Tick(Tick),
    .OutData(OutData),
    .OutIndex(OutIndex),
    .OutValid(OutValid),
    .Busy(Busy),
    .Done(Done)
  );
  tick_generator #(.TickDivide(1)) u_tick1 (
    .Clock(Clock),
    .Reset(Reset),
    .Tick(tick1)
  );
  always #5 Clock = ~Clock;
  always_comb begin
    BusIn = '0;
    for (int i = 0; i < 4; i++) if (!cs[i]) BusIn = regs[i];
  end
  always @(posedge Clock or posedge Reset)
    if (Reset) jcnt <= 0;
    else jcnt <= jcnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge Clock) begin
    if (Reset) sb.delete();
    chk("cs_at_most_one", $countones(~cs) <= 1, 1);
    chk("cs_only_in_select", $countones(~cs) == 1, Busy && !OutValid && !Done);
    chk("tick_div3", Tick, !Reset && (jcnt % 3 == 2));
    chk("tick_div1", tick1, !Reset && (jcnt >= 1));
    if (Done) done_cnt++;
    if (OutValid && OutReady && !Reset) begin
      acc_cnt++;
      chk("word_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_w = sb.pop_front();
        chk("word_data", OutData, mon_w.d);
        chk("word_index", OutIndex, mon_w.i);
      end
    end
  end
  task automatic push_scan();
    for (int i = 0; i < 4; i++) sb.push_back('{d: regs[i], i: 2'(i)});
  endtask
  task automatic start_scan();
    Start = 1'b1;
    push_scan();
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge Clock);
      seen = OutValid;
      n++;
    end
    chk("valid_timeout", seen, 1);
  endtask
  task automatic accept_one();
    @(posedge Clock); #1;
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
  endtask
  task automatic wait_done(input bit rb);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge Clock);
      seen = Done;
      n++;
      if (!seen) begin
        @(posedge Clock); #1;
        if (rb) OutReady = 1'($urandom_range(0, 1));
      end
    end
    chk("done_timeout", seen, 1);
    if (seen) exp_done++;
  endtask
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    OutReady = 1'b1;
    regs = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_cs", cs, 4'hf);
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_data", OutData, 0);
    chk("rst_index", OutIndex, 0);
    chk("rst_tick", Tick, 0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    // basic scan: valid 1,3,5,7 and done 8 edges after the Start edge
    start_scan();
    for (int e = 0; e < 10; e++) begin
      @(negedge Clock);
      vmask[e] = OutValid;
      dmask[e] = Done;
    end
    chk("basic_valid_timing", vmask, 10'b0010101010);
    chk("basic_done_timing", dmask, 10'b0100000000);
    exp_done++;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    start_scan();
    wait_valid();
    accept_one();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clock);
      chk("bp_data", OutData, regs[1]);
      chk("bp_index", OutIndex, 1);
      chk("bp_cs", cs, 4'hf);
      chk("bp_valid", OutValid, 1);
    end
    @(posedge Clock); #1;
    OutReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("bp_bubble", OutValid, 0);
    @(negedge Clock);
    chk("bp_next_valid", OutValid, 1);
    chk("bp_next_index", OutIndex, 2);
    wait_done(0);
    @(posedge Clock); #1;
    a0 = acc_cnt;
    start_scan();
    @(posedge Clock); #1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done(1);
    chk("start_ignored_words", acc_cnt - a0, 4);
    @(posedge Clock); #1;
    OutReady = 1'b1;
    Start = 1'b1;
    push_scan();
    push_scan();
    wait_done(0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_valid();
    chk("restart_index", OutIndex, 0);
    wait_done(0);
    for (int s = 0; s < 6; s++) begin
      @(posedge Clock); #1;
      for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
      start_scan();
      wait_done(1);
    end
    // reset while word 2 is being offered; the scan is abandoned
    @(posedge Clock); #1;
    OutReady = 1'b0;
    start_scan();
    wait_valid();
    accept_one();
    wait_valid();
    accept_one();
    wait_valid();
    chk("pre_reset_index", OutIndex, 2);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_cs", cs, 4'hf);
    chk("async_rst_valid", OutValid, 0);
    chk("async_rst_busy", Busy, 0);
    chk("async_rst_done", Done, 0);
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;
    OutReady = 1'b1;
    @(posedge Clock); #1;
    start_scan();
    wait_valid();
    chk("post_reset_index", OutIndex, 0);
    chk("post_reset_data", OutData, regs[0]);
    wait_done(0);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    chk("done_count", done_cnt, exp_done);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/register_bank_scanner.md
# register_bank_scanner

Sequencer that sits between the memory stage's bank of tri-state clear/preset registers and the recognition datapath. It generates the bank's shared `Tick` enable. On request it walks the bank one register at a time, enabling each register's output onto the shared bus through its `cs` line, then captures the word. Each captured word is handed downstream over a valid/ready handshake, so the register bank can be read out serially without bus contention.

## Interface
Parameters:
- `NrOfBits`, 8, width of each register and of the shared bus
- `NrOfRegs`, 4, registers in the bank (≥1); index width `IdxW = max(1, clog2(NrOfRegs))`
- `TickDivide`, 1, `Tick` period in `Clock` cycles (≥1)

Ports:
- `Clock`  in  1  single system clock; all state on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Start`  in  1  scan request, sampled only in IDLE
- `BusIn`  in  NrOfBits  shared tri-state register bus (wired Q outputs)
- `OutReady`  in  1  downstream ready
- `cs`  out  NrOfRegs  per-register output disable; 1 = register output high-Z, 0 = drives bus
- `Tick`  out  1  bank-wide clock-enable tick
- `OutData`  out  NrOfBits  captured word
- `OutIndex`  out  IdxW  register index of `OutData`
- `OutValid`  out  1  `OutData`/`OutIndex` valid
- `Busy`  out  1  scan in progress (state ≠ IDLE)
- `Done`  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, SELECT, OUTPUT, DONE.
- **IDLE**
  - `cs` all ones.
  - `Start`=1 → SELECT with idx=0.
- **SELECT** (exactly one cycle)
  - `cs[idx]`=0, all other bits 1.
  - On the exiting edge, `BusIn` → `OutData` and idx → `OutIndex`; next state OUTPUT.
- **OUTPUT**
  - `cs` all ones; `OutValid`=1; `OutData` and `OutIndex` held stable.
  - On an edge with `OutReady`=1:
    - idx = NrOfRegs-1 → DONE;
    - otherwise idx+1 → SELECT.
  - `OutReady`=0 → stay, for any number of cycles.
- **DONE**
  - `Done`=1 for one cycle, then IDLE.
- Never more than one `cs` bit is 0 in any cycle. This is guaranteed by construction and is a verification assertion.
- `Start` is ignored while `Busy`. `Start` held high through DONE begins a new scan on the first IDLE cycle.
- Tick generator:
  - Free-running counter 0..TickDivide-1; `Tick`=1 in the cycle the counter equals TickDivide-1.
  - TickDivide=1 → `Tick`=1 every cycle after reset.
  - The counter is independent of the scan FSM.
- Index arithmetic is unsigned IdxW-bit. It never wraps, because the last index exits to DONE.
- Reset (asynchronous, any state):
  - State → IDLE, idx=0, tick counter=0.
  - `cs` all ones, `Tick`=0, `OutValid`=0, `Busy`=0, `Done`=0, `OutData`=0, `OutIndex`=0.
  - A scan interrupted by reset is abandoned; there is no partial `Done`.

## Timing
- Start→first `OutValid`: `Start` high at edge k → SELECT in cycle k+1 → `OutValid` in cycle k+2.
- Accept→next `OutValid`: 2 cycles (one SELECT bubble). Full scan with `OutReady` tied 1 takes 2·NrOfRegs+1 cycles from `Start` edge to `Done`.
- `cs` is registered (decoded from state/idx registers, glitch-free). The bus settle budget is one full clock period.
- All outputs are registered or decoded from registered state only. No combinational path from `OutReady` or `Start` to any output.

## Structure
- Shared package `scanner_pkg`:
  - state encoding constants (IDLE=0, SELECT=1, OUTPUT=2, DONE=3);
  - `clog2` function.
- Sub-module `tick_generator` (parameter `TickDivide`; ports `Clock`, `Reset`, `Tick`) holds the divider counter. The FSM, index register and capture register stay in the top module.

## Test plan
- **Reset:** assert `Reset` mid-OUTPUT (idx=2).
  - → asynchronously `cs`=4'b1111, `OutValid`=0, `Busy`=0.
  - After release, a new `Start` reads from idx 0.
- **Basic scan** (NrOfRegs=4, `OutReady`=1, registers 0x11/0x22/0x33/0x44):
  - → words 0x11..0x44 with `OutIndex` 0..3, `OutValid` in cycles k+2, k+4, k+6, k+8.
  - `Done` in cycle k+9.
- **Backpressure:** `OutReady`=0 for 5 cycles on word 1.
  - → `OutData`=0x22 and `OutIndex`=1 held, `cs` all ones throughout.
  - Word 2 appears 2 cycles after `OutReady` rises.
- **Bus exclusivity:** monitor every cycle of a random-backpressure scan.
  - → popcount(~`cs`) ≤ 1, and =1 only in SELECT.
- **Tick:** TickDivide=3.
  - → `Tick` high in cycles 2, 5, 8… after reset release, unaffected by `Start`.
  - TickDivide=1 → `Tick` high every cycle.
- **Start handling:** `Start` pulsed during a scan → ignored, exactly 4 words.
  - `Start` held high through DONE → second scan begins with `OutIndex`=0.
